// File: rtl/psc_pkg.sv
// Shared constants, counter-action encoding and a constant-evaluable clog2
// for the prescaled up/down counter family.
package psc_pkg;

  localparam int unsigned SAT_WRAP = 0;
  localparam int unsigned SAT_HOLD = 1;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_CLR,
    ACT_LOAD,
    ACT_STEP
  } cnt_act_e;

  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      if ((64'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV enable: one-cycle registered tick every DIV clocks,
// restartable with a synchronous clear. Usable standalone for enable generation.
module tick_prescaler
  import psc_pkg::*;
#(
  parameter int unsigned DIV = 1200000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DIV_W = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_tick;

  // With DIV=1, LAST is 0 so tick stays high on every edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else if (clr) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_tick    <= (r_div_cnt == LAST);
      r_div_cnt <= (r_div_cnt == LAST) ? '0 : r_div_cnt + DIV_W'(1);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/prescaled_updown_counter.sv
// Prescaled WIDTH-bit up/down counter with clear, clamped load, wrap/hold policy
// and terminal-count pulse. Define PSC_INPUT_SYNC_EN to 2-flop synchronize controls.
module prescaled_updown_counter
  import psc_pkg::*;
#(
  parameter int unsigned     WIDTH = 4,
  parameter int unsigned     DIV   = 1200000,
  parameter longint unsigned MAX   = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     SAT   = SAT_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             cnt_zero
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic w_run;
  logic w_up_dn;
  logic w_clr;
  logic w_load;

`ifdef PSC_INPUT_SYNC_EN
  logic [3:0] r_sync_q1;
  logic [3:0] r_sync_q2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync_q1 <= '0;
      r_sync_q2 <= '0;
    end else begin
      r_sync_q1 <= {run, up_dn, clr, load};
      r_sync_q2 <= r_sync_q1;
    end
  end

  assign {w_run, w_up_dn, w_clr, w_load} = r_sync_q2;
`else
  assign w_run   = run;
  assign w_up_dn = up_dn;
  assign w_clr   = clr;
  assign w_load  = load;
`endif

  logic w_tick;

  tick_prescaler #(
    .DIV (DIV)
  ) u_tick_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  logic [WIDTH-1:0] r_cnt;
  logic             r_tc;
  cnt_act_e         w_act;
  logic             w_at_bound;
  logic [WIDTH-1:0] w_step_val;
  logic [WIDTH-1:0] w_load_val;

  always_comb begin
    w_act = ACT_HOLD;
    if (w_clr)                w_act = ACT_CLR;
    else if (w_load)          w_act = ACT_LOAD;
    else if (w_tick && w_run) w_act = ACT_STEP;
  end

  always_comb begin
    w_at_bound = w_up_dn ? (r_cnt == MAX_V) : (r_cnt == '0);
    w_load_val = (load_val > MAX_V) ? MAX_V : load_val;
    w_step_val = r_cnt;
    if (w_up_dn) begin
      if (r_cnt != MAX_V)      w_step_val = r_cnt + WIDTH'(1);
      else if (SAT != SAT_HOLD) w_step_val = '0;
    end else begin
      if (r_cnt != '0)         w_step_val = r_cnt - WIDTH'(1);
      else if (SAT != SAT_HOLD) w_step_val = MAX_V;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_tc  <= 1'b0;
    end else begin
      case (w_act)
        ACT_CLR: begin
          r_cnt <= '0;
          r_tc  <= 1'b0;
        end
        ACT_LOAD: begin
          r_cnt <= w_load_val;
          r_tc  <= 1'b0;
        end
        ACT_STEP: begin
          r_cnt <= w_step_val;
          r_tc  <= w_at_bound;
        end
        default: r_tc <= 1'b0;
      endcase
    end
  end

  assign tick     = w_tick;
  assign cnt      = r_cnt;
  assign tc       = r_tc;
  assign cnt_zero = (r_cnt == '0);

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Directed bench for prescaled_updown_counter: four instances share stimulus
// (A: wrap/MAX15, B: hold/MAX15, C: wrap/MAX9, D: DIV=1).
module tb_prescaled_updown_counter;

`ifdef PSC_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       reset;
  logic       run;
  logic       up_dn;
  logic       clr;
  logic       load;
  logic [3:0] load_val;

  logic       a_tick, b_tick, c_tick, d_tick;
  logic [3:0] a_cnt, b_cnt, c_cnt, d_cnt;
  logic       a_tc, b_tc, c_tc, d_tc;
  logic       a_zero, b_zero, c_zero, d_zero;

  int tests = 0;
  int fails = 0;
  int edge_k = 0;

  prescaled_updown_counter #(.WIDTH(4), .DIV(4), .MAX(15), .SAT(0)) u_a (
    .clk(clk), .reset(reset), .run(run), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .tick(a_tick), .cnt(a_cnt), .tc(a_tc), .cnt_zero(a_zero));

  prescaled_updown_counter #(.WIDTH(4), .DIV(4), .MAX(15), .SAT(1)) u_b (
    .clk(clk), .reset(reset), .run(run), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .tick(b_tick), .cnt(b_cnt), .tc(b_tc), .cnt_zero(b_zero));

  prescaled_updown_counter #(.WIDTH(4), .DIV(4), .MAX(9), .SAT(0)) u_c (
    .clk(clk), .reset(reset), .run(run), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .tick(c_tick), .cnt(c_cnt), .tc(c_tc), .cnt_zero(c_zero));

  prescaled_updown_counter #(.WIDTH(4), .DIV(1), .MAX(15), .SAT(0)) u_d (
    .clk(clk), .reset(reset), .run(run), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .tick(d_tick), .cnt(d_cnt), .tc(d_tc), .cnt_zero(d_zero));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
    edge_k++;
  endtask

  // Pulse clr; edge_k restarts at 0 on the edge where clr actually takes effect.
  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (LAT) step();
    edge_k = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0;
    repeat (3) step();
    tests++;
    if ({a_tick, a_cnt, a_tc, a_zero, d_tick} !== {1'b0, 4'd0, 1'b0, 1'b1, 1'b0}) begin
      $display("FAIL reset_state: tick/cnt/tc/zero/dtick got %b %0d %b %b %b expected 0 0 0 1 0",
               a_tick, a_cnt, a_tc, a_zero, d_tick);
      fails++;
    end
    reset = 1'b0;
    edge_k = 0;
  endtask

  task automatic test_count_up();
    while (edge_k < 66) begin
      step();
      case (edge_k)
        1, 2, 3, 5: begin
          tests++;
          if (a_tick !== 1'b0) begin
            $display("FAIL up_tick_low@%0d: got %b expected 0", edge_k, a_tick); fails++;
          end
        end
        4, 8, 12: begin
          tests++;
          if ({a_tick, d_tick} !== 2'b11) begin
            $display("FAIL up_tick_high@%0d: a/d tick got %b%b expected 11", edge_k, a_tick, d_tick);
            fails++;
          end
        end
        default: ;
      endcase
      if (edge_k == 9) begin
        tests++;
        if (a_cnt !== 4'd2) begin
          $display("FAIL up_cnt@9: got %0d expected 2", a_cnt); fails++;
        end
      end
      if (edge_k == 41) begin
        tests++;
        if ({c_cnt, c_tc} !== {4'd0, 1'b1}) begin
          $display("FAIL max9_wrap: cnt/tc got %0d %b expected 0 1", c_cnt, c_tc); fails++;
        end
      end
      if (edge_k == 64) begin
        tests++;
        if ({a_cnt, a_tc} !== {4'd15, 1'b0}) begin
          $display("FAIL up_cnt@64: cnt/tc got %0d %b expected 15 0", a_cnt, a_tc); fails++;
        end
      end
      if (edge_k == 65) begin
        tests++;
        if ({a_cnt, a_tc, b_cnt, b_tc} !== {4'd0, 1'b1, 4'd15, 1'b1}) begin
          $display("FAIL up_wrap: a cnt/tc %0d %b b cnt/tc %0d %b expected 0 1 15 1",
                   a_cnt, a_tc, b_cnt, b_tc);
          fails++;
        end
      end
      if (edge_k == 66) begin
        tests++;
        if ({a_tc, b_tc} !== 2'b00) begin
          $display("FAIL up_tc_width: a/b tc got %b%b expected 00", a_tc, b_tc); fails++;
        end
      end
    end
  endtask

  task automatic test_down_boundary();
    run = 1'b1; up_dn = 1'b0;
    do_clr();
    tests++;
    if ({a_cnt, a_tick, a_tc, d_tick} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL clr_state: cnt/tick/tc/dtick got %0d %b %b %b expected 0 0 0 0",
               a_cnt, a_tick, a_tc, d_tick);
      fails++;
    end
    while (edge_k < 9) begin
      step();
      if (edge_k == 5) begin
        tests++;
        if ({a_cnt, a_tc, b_cnt, b_tc, c_cnt, c_tc} !== {4'd15, 1'b1, 4'd0, 1'b1, 4'd9, 1'b1}) begin
          $display("FAIL down_underflow: a %0d/%b b %0d/%b c %0d/%b expected 15/1 0/1 9/1",
                   a_cnt, a_tc, b_cnt, b_tc, c_cnt, c_tc);
          fails++;
        end
      end
      if (edge_k == 6) begin
        tests++;
        if (b_tc !== 1'b0) begin
          $display("FAIL sat_tc_width: got %b expected 0", b_tc); fails++;
        end
      end
      if (edge_k == 9) begin
        tests++;
        if ({a_cnt, a_tc, b_cnt, b_tc, b_zero} !== {4'd14, 1'b0, 4'd0, 1'b1, 1'b1}) begin
          $display("FAIL down_hold_repeat: a %0d/%b b %0d/%b zero %b expected 14/0 0/1 1",
                   a_cnt, a_tc, b_cnt, b_tc, b_zero);
          fails++;
        end
      end
    end
  endtask

  task automatic test_load_clamp();
    run = 1'b1; up_dn = 1'b1;
    do_clr();
    load = 1'b1; load_val = 4'd13;
    step();
    load = 1'b0;
    repeat (LAT) step();
    tests++;
    if ({a_cnt, c_cnt} !== {4'd13, 4'd9}) begin
      $display("FAIL load_clamp: a/c cnt got %0d %0d expected 13 9", a_cnt, c_cnt); fails++;
    end
    while (edge_k < 5) step();
    tests++;
    if ({a_cnt, a_tc, c_cnt, c_tc} !== {4'd14, 1'b0, 4'd0, 1'b1}) begin
      $display("FAIL load_then_step: a %0d/%b c %0d/%b expected 14/0 0/1", a_cnt, a_tc, c_cnt, c_tc);
      fails++;
    end
  endtask

  task automatic test_clr_load_together();
    run = 1'b1; up_dn = 1'b1;
    do_clr();
    load = 1'b1; load_val = 4'd3;
    step();
    load = 1'b0;
    repeat (LAT) step();
    while (edge_k < 8 - LAT) step();
    clr = 1'b1; load = 1'b1; load_val = 4'd5;
    step();
    clr = 1'b0; load = 1'b0;
    repeat (LAT) step();
    tests++;
    if ({a_cnt, a_tc, a_tick} !== {4'd0, 1'b0, 1'b0}) begin
      $display("FAIL clr_over_load: cnt/tc/tick got %0d %b %b expected 0 0 0", a_cnt, a_tc, a_tick);
      fails++;
    end
    edge_k = 0;
    while (edge_k < 5) begin
      step();
      if (edge_k == 3) begin
        tests++;
        if (a_tick !== 1'b0) begin
          $display("FAIL clr_restart_early: tick got %b expected 0", a_tick); fails++;
        end
      end
      if (edge_k == 4) begin
        tests++;
        if (a_tick !== 1'b1) begin
          $display("FAIL clr_restart_tick: tick got %b expected 1", a_tick); fails++;
        end
      end
    end
    tests++;
    if (a_cnt !== 4'd1) begin
      $display("FAIL clr_restart_cnt: got %0d expected 1", a_cnt); fails++;
    end
  endtask

  task automatic test_run_hold();
    int bad;
    bad = 0;
    run = 1'b0; up_dn = 1'b1;
    do_clr();
    load = 1'b1; load_val = 4'd6;
    step();
    load = 1'b0;
    repeat (LAT) step();
    while (edge_k < 42) begin
      step();
      if (a_cnt !== 4'd6 || a_tc !== 1'b0) bad++;
      up_dn = ~up_dn;
    end
    tests++;
    if (bad !== 0) begin
      $display("FAIL run_off_hold: cycles with cnt!=6 or tc=1 got %0d expected 0", bad); fails++;
    end
    // up_dn is high only in tick cycles (after sync latency) and low everywhere else.
    run = 1'b1;
    up_dn = ((edge_k + LAT) % 4 == 0);
    while (edge_k < 61) begin
      step();
      up_dn = ((edge_k + LAT) % 4 == 0);
    end
    tests++;
    if ({a_cnt, a_tc} !== {4'd11, 1'b0}) begin
      $display("FAIL updn_dont_care: cnt/tc got %0d %b expected 11 0", a_cnt, a_tc); fails++;
    end
  endtask

  task automatic test_async_reset();
    run = 1'b1; up_dn = 1'b1;
    do_clr();
    load = 1'b1; load_val = 4'd7;
    step();
    load = 1'b0;
    repeat (LAT) step();
    while (edge_k < 4) step();
    tests++;
    if ({a_cnt, a_tick} !== {4'd7, 1'b1}) begin
      $display("FAIL pre_reset: cnt/tick got %0d %b expected 7 1", a_cnt, a_tick); fails++;
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({a_cnt, a_tick, a_tc, a_zero} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      $display("FAIL async_reset: cnt/tick/tc/zero got %0d %b %b %b expected 0 0 0 1",
               a_cnt, a_tick, a_tc, a_zero);
      fails++;
    end
    #1 reset = 1'b0;
    edge_k = 0;
    while (edge_k < 5) begin
      step();
      if (edge_k == 4) begin
        tests++;
        if ({a_tick, a_cnt} !== {1'b1, 4'd0}) begin
          $display("FAIL reset_resume_tick: tick/cnt got %b %0d expected 1 0", a_tick, a_cnt); fails++;
        end
      end
    end
    tests++;
    if (a_cnt !== 4'd1) begin
      $display("FAIL reset_resume_cnt: got %0d expected 1", a_cnt); fails++;
    end
  endtask

  task automatic test_load_latency();
    run = 1'b0;
    do_clr();
    load = 1'b1; load_val = 4'd3;
    step();
    load = 1'b0;
    tests++;
    if (a_cnt !== ((LAT == 0) ? 4'd3 : 4'd0)) begin
      $display("FAIL load_lat_first_edge: got %0d expected %0d", a_cnt, (LAT == 0) ? 3 : 0); fails++;
    end
    repeat (LAT) step();
    tests++;
    if (a_cnt !== 4'd3) begin
      $display("FAIL load_lat_effect: got %0d expected 3", a_cnt); fails++;
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_down_boundary();
    test_load_clamp();
    test_clr_load_together();
    test_run_hold();
    test_async_reset();
    test_load_latency();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
